// File: rtl/position_scanner_pkg.sv
// Shared widths, state encoding and constants for the sprite position scanner
// and anything else that consumes the position table.
package pos_pkg;
  localparam int ADDR_W  = 2;
  localparam int ID_W    = 2;
  localparam int COORD_W = 9;

  localparam logic [ID_W-1:0] ID_INACTIVE = 2'd0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    LOAD,
    WAIT_DONE,
    NEXT
  } scan_state_t;
endpackage

// File: rtl/position_scanner_if.sv
// Table read port plus position-buffer load/ack bundle; master is the scanner.
interface position_scanner_if;
  logic                        RD_EN;
  logic [pos_pkg::ADDR_W-1:0]  RD_ADDR;
  logic [pos_pkg::ID_W-1:0]    RD_ID_CODE;
  logic [pos_pkg::COORD_W-1:0] RD_X;
  logic [pos_pkg::COORD_W-1:0] RD_Y;
  logic                        BUFFER_LOAD;
  logic [pos_pkg::ADDR_W-1:0]  ADDR_OUT;
  logic [pos_pkg::ID_W-1:0]    ID_CODE_OUT;
  logic [pos_pkg::COORD_W-1:0] X_OUT;
  logic [pos_pkg::COORD_W-1:0] Y_OUT;
  logic                        DRAW_DONE;

  modport master (
    output RD_EN, RD_ADDR,
    input  RD_ID_CODE, RD_X, RD_Y,
    output BUFFER_LOAD, ADDR_OUT, ID_CODE_OUT, X_OUT, Y_OUT,
    input  DRAW_DONE
  );

  modport slave (
    input  RD_EN, RD_ADDR,
    output RD_ID_CODE, RD_X, RD_Y,
    input  BUFFER_LOAD, ADDR_OUT, ID_CODE_OUT, X_OUT, Y_OUT,
    output DRAW_DONE
  );
endinterface

// File: rtl/position_scanner_bounds_check.sv
// Combinational sprite visibility test: active ID and on-screen coordinates.
module position_bounds_check
  import pos_pkg::*;
#(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic [ID_W-1:0]    id,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               valid
);
  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H);

  assign valid = (id != ID_INACTIVE) && (x < X_LIM) && (y < Y_LIM);
endmodule

// File: rtl/position_scanner.sv
// Per-frame walk of the sprite position table, handing each visible entry to
// the position buffer and waiting for the renderer before the next one.
module position_scanner
  import pos_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int SCREEN_W    = 320,
  parameter int SCREEN_H    = 240
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic                FRAME_START,
  position_scanner_if.master  bus,
  output logic                BUSY,
  output logic                FRAME_DONE,
  output logic                FRAME_OVERRUN
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ENTRIES - 1);

  scan_state_t        state, nxt;
  logic [ADDR_W-1:0]  idx;
  logic [ADDR_W-1:0]  addr_q;
  logic [ID_W-1:0]    id_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic               ovr_q;
  logic               ent_valid;

  position_bounds_check #(
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H)
  ) u_bounds (
    .id    (bus.RD_ID_CODE),
    .x     (bus.RD_X),
    .y     (bus.RD_Y),
    .valid (ent_valid)
  );

  always_ff @(posedge CLOCK_50) begin
    if (RESET) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (FRAME_START) nxt = FETCH;
      FETCH:     nxt = WAIT_DATA;
      WAIT_DATA: nxt = ent_valid ? LOAD : NEXT;
      LOAD:      nxt = WAIT_DONE;
      WAIT_DONE: if (bus.DRAW_DONE) nxt = NEXT;
      NEXT:      nxt = (idx == LAST_IDX) ? IDLE : FETCH;
      default:   nxt = IDLE;
    endcase
  end

  // Output data registers only move on a valid capture, so the buffer side
  // keeps seeing the last loaded sprite through skips and idle time.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      idx    <= '0;
      addr_q <= '0;
      id_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      ovr_q  <= 1'b0;
    end else begin
      ovr_q <= FRAME_START && (state != IDLE);
      if (state == IDLE && FRAME_START) idx <= '0;
      if (state == NEXT && idx != LAST_IDX) idx <= idx + ADDR_W'(1);
      if (state == WAIT_DATA && ent_valid) begin
        addr_q <= idx;
        id_q   <= bus.RD_ID_CODE;
        x_q    <= bus.RD_X;
        y_q    <= bus.RD_Y;
      end
    end
  end

  always_comb begin
    bus.RD_EN       = (state == FETCH);
    bus.RD_ADDR     = (state == FETCH) ? idx : '0;
    bus.BUFFER_LOAD = (state == LOAD);
    BUSY            = (state != IDLE);
    FRAME_DONE      = (state == NEXT) && (idx == LAST_IDX);
  end

  assign bus.ADDR_OUT    = addr_q;
  assign bus.ID_CODE_OUT = id_q;
  assign bus.X_OUT       = x_q;
  assign bus.Y_OUT       = y_q;
  assign FRAME_OVERRUN   = ovr_q;
endmodule

// File: tb/tb_position_scanner.sv
// Directed bench for position_scanner: 1-cycle table model, auto DRAW_DONE
// two cycles after each load, negedge monitor with frame-relative timing.
module tb_position_scanner;
  import pos_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic busy, frame_done, frame_overrun;

  position_scanner_if bus();

  position_scanner #(
    .NUM_ENTRIES(4),
    .SCREEN_W(320),
    .SCREEN_H(240)
  ) dut (
    .CLOCK_50      (clk),
    .RESET         (rst),
    .FRAME_START   (frame_start),
    .bus           (bus),
    .BUSY          (busy),
    .FRAME_DONE    (frame_done),
    .FRAME_OVERRUN (frame_overrun)
  );

  // table model
  logic [1:0] t_id [4];
  logic [8:0] t_x  [4];
  logic [8:0] t_y  [4];
  logic [1:0] q_id = '0;
  logic [8:0] q_x  = '0;
  logic [8:0] q_y  = '0;
  always @(posedge clk) begin
    if (bus.RD_EN) begin
      q_id <= t_id[bus.RD_ADDR];
      q_x  <= t_x[bus.RD_ADDR];
      q_y  <= t_y[bus.RD_ADDR];
    end
  end
  assign bus.RD_ID_CODE = q_id;
  assign bus.RD_X       = q_x;
  assign bus.RD_Y       = q_y;

  // renderer model
  logic [1:0] dd_pipe = '0;
  logic auto_done = 1'b1;
  logic man_done  = 1'b0;
  always @(posedge clk) dd_pipe <= {dd_pipe[0], bus.BUFFER_LOAD};
  assign bus.DRAW_DONE = auto_done ? dd_pipe[1] : man_done;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int start_cyc = 0;
  int n_load = 0, n_done = 0, n_ovr = 0, n_rden = 0;
  int done_rel = -1, first_load_rel = -1;
  int ld_addr [8];
  int ld_x    [8];
  int ld_y    [8];
  int ovr_rel [4];

  always @(negedge clk) begin
    if (bus.RD_EN) n_rden++;
    if (bus.BUFFER_LOAD) begin
      if (n_load == 0) first_load_rel = cyc - start_cyc;
      if (n_load < 8) begin
        ld_addr[n_load] = int'(bus.ADDR_OUT);
        ld_x[n_load]    = int'(bus.X_OUT);
        ld_y[n_load]    = int'(bus.Y_OUT);
      end
      n_load++;
    end
    if (frame_done) begin
      done_rel = cyc - start_cyc;
      n_done++;
    end
    if (frame_overrun) begin
      if (n_ovr < 4) ovr_rel[n_ovr] = cyc - start_cyc;
      n_ovr++;
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int outs();
    return int'({busy, bus.RD_EN, bus.RD_ADDR, bus.BUFFER_LOAD, bus.ADDR_OUT,
                 bus.ID_CODE_OUT, bus.X_OUT, bus.Y_OUT, frame_done, frame_overrun});
  endfunction

  task automatic set_ent(input int e, input int id, input int x, input int y);
    t_id[e] = 2'(id);
    t_x[e]  = 9'(x);
    t_y[e]  = 9'(y);
  endtask

  // clear monitor state mid-cycle, away from the negedge monitor
  task automatic arm();
    @(posedge clk); #1;
    n_load = 0; n_done = 0; n_ovr = 0; n_rden = 0;
    done_rel = -1; first_load_rel = -1;
    start_cyc = cyc;
  endtask

  task automatic pulse_start();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (n_done == 0) chk({tag, "_timeout"}, n_done, 1);
  endtask

  task automatic load_all_valid();
    set_ent(0, 1, 10, 5);
    set_ent(1, 2, 20, 5);
    set_ent(2, 3, 30, 5);
    set_ent(3, 1, 40, 5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int e = 0; e < 4; e++) set_ent(e, 0, 0, 0);

    // reset then idle
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", outs(), 0);
    rst = 1'b0;
    arm();
    repeat (6) @(posedge clk);
    #1;
    chk("idle_rden", n_rden, 0);
    chk("idle_busy", int'(busy), 0);

    // all four entries valid
    load_all_valid();
    arm();
    pulse_start();
    wait_done("allv", 200);
    chk("allv_first_rel", first_load_rel, 3);
    chk("allv_x0", ld_x[0], 10);
    chk("allv_y0", ld_y[0], 5);
    chk("allv_nload", n_load, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("allv_addr%0d", i), ld_addr[i], i);
    chk("allv_done_rel", done_rel, 24);
    @(posedge clk); #1;
    chk("allv_ndone", n_done, 1);
    chk("allv_busy", int'(busy), 0);

    // all entries invalid: outputs keep entry 3 of the previous frame
    set_ent(0, 0, 10, 5);
    set_ent(1, 1, 320, 5);
    set_ent(2, 2, 10, 240);
    set_ent(3, 3, 511, 511);
    arm();
    pulse_start();
    wait_done("inv", 200);
    chk("inv_nload", n_load, 0);
    chk("inv_done_rel", done_rel, 12);
    chk("inv_x_hold", int'(bus.X_OUT), 40);
    chk("inv_y_hold", int'(bus.Y_OUT), 5);
    chk("inv_addr_hold", int'(bus.ADDR_OUT), 3);
    chk("inv_id_hold", int'(bus.ID_CODE_OUT), 1);

    // only entry 2, on the inclusive screen edge
    set_ent(0, 0, 1, 1);
    set_ent(1, 1, 320, 1);
    set_ent(2, 2, 319, 239);
    set_ent(3, 3, 1, 240);
    arm();
    pulse_start();
    wait_done("edge", 200);
    chk("edge_nload", n_load, 1);
    chk("edge_addr", ld_addr[0], 2);
    chk("edge_x", ld_x[0], 319);
    chk("edge_y", ld_y[0], 239);
    chk("edge_id", int'(bus.ID_CODE_OUT), 2);
    chk("edge_done_rel", done_rel, 15);

    // frame start in WAIT_DONE (rel 4) and in the final NEXT (rel 24)
    load_all_valid();
    arm();
    @(negedge clk); frame_start = 1'b1;
    for (int r = 1; r <= 40; r++) begin
      @(negedge clk);
      frame_start = (r == 4 || r == 24);
    end
    frame_start = 1'b0;
    @(posedge clk); #1;
    chk("ovr_count", n_ovr, 2);
    chk("ovr_rel0", ovr_rel[0], 5);
    chk("ovr_rel1", ovr_rel[1], 25);
    chk("ovr_ndone", n_done, 1);
    chk("ovr_done_rel", done_rel, 24);
    chk("ovr_nload", n_load, 4);
    chk("ovr_rden", n_rden, 4);
    chk("ovr_busy", int'(busy), 0);

    // reset while waiting on the entry-1 draw
    load_all_valid();
    arm();
    pulse_start();
    begin
      int k = 0;
      while (n_load < 2 && k < 100) begin
        @(posedge clk); #1;
        k++;
      end
    end
    chk("rstmid_nload", n_load, 2);
    auto_done = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_outs", outs(), 0);
    rst = 1'b0;
    man_done = 1'b1;
    @(posedge clk); #1;
    man_done = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rstmid_ndone", n_done, 0);
    chk("rstmid_nload_after", n_load, 2);
    chk("rstmid_rden", n_rden, 2);
    chk("rstmid_busy", int'(busy), 0);
    auto_done = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
